// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle RV32M sequencer, radix-2 shift-add multiplier and restoring divider
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] res_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [2*XLEN-1:0] acc, mcand, acc_n, a_ext;
  logic [XLEN-1:0] mplier, rem, quot, dvsr, rem_n, quot_n, mag1, mag2, spec_res, calc_res;
  logic [XLEN:0] sh;
  logic neg_q, neg_r, accept, sgn_div, dz, ovf, special, last, ge, b_neg;
  assign accept  = state == IDLE && start_i && !flush_i;
  assign sgn_div = !op_i[0];
  assign dz      = op2_i == '0;
  assign ovf     = sgn_div && op1_i == MIN_NEG && &op2_i;
  assign special = op_i[2] && (dz || ovf);
  assign spec_res = dz ? (op_i[1] ? op1_i : '1) : (op_i[1] ? '0 : MIN_NEG);
  assign a_ext   = {{XLEN{(op_i == 3'b001 || op_i == 3'b010) && op1_i[XLEN-1]}}, op1_i};
  assign b_neg   = op_i == 3'b001 && op2_i[XLEN-1];
  assign mag1    = sgn_div && op1_i[XLEN-1] ? -op1_i : op1_i;
  assign mag2    = sgn_div && op2_i[XLEN-1] ? -op2_i : op2_i;
  // a signed multiplier's top bit weighs -2^(XLEN-1): pre-load -(a << XLEN) to fold in its sign extension
  assign acc_n   = mplier[0] ? acc + mcand : acc;
  assign sh      = {rem, quot[XLEN-1]};
  assign ge      = sh >= {1'b0, dvsr};
  assign rem_n   = ge ? sh[XLEN-1:0] - dvsr : sh[XLEN-1:0];
  assign quot_n  = {quot[XLEN-2:0], ge};
  assign last    = cnt == CW'(XLEN-1);
  assign calc_res = op_q[2] ? (op_q[1] ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quot_n : quot_n))
                            : (op_q[1:0] == 2'b00 ? acc_n[XLEN-1:0] : acc_n[2*XLEN-1:XLEN]);
  assign busy_o  = state != IDLE;
  assign valid_o = state == DONE;
  always_comb begin
    state_n = flush_i ? IDLE
            : state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE)
            : state == CALC ? (last ? DONE : CALC)
            : IDLE;
    stall_o = accept || state == CALC;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quot   <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      res_o  <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= op_i;
      acc    <= b_neg ? -(a_ext << XLEN) : '0;
      mcand  <= a_ext;
      mplier <= op2_i;
      rem    <= '0;
      quot   <= mag1;
      dvsr   <= mag2;
      neg_q  <= sgn_div && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
      neg_r  <= sgn_div && op1_i[XLEN-1];
      if (special) res_o <= spec_res;
    end else if (state == CALC && !flush_i) begin
      cnt    <= cnt + CW'(1);
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_n;
      quot   <= quot_n;
      if (last) res_o <= calc_res;
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors for muldiv_ctrl with hand-computed results and latencies
module tb_muldiv_ctrl;
  logic clk = 0, reset_n = 0, start_i = 0, flush_i = 0;
  logic [2:0] op_i = '0;
  logic [31:0] op1_i = '0, op2_i = '0, res_o;
  logic stall_o, busy_o, valid_o;
  int total = 0, bad = 0;
  muldiv_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .op_i(op_i), .op1_i(op1_i),
    .op2_i(op2_i), .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
    .valid_o(valid_o), .res_o(res_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int n, st;
    bit seen;
    @(negedge clk);
    op_i = op; op1_i = a; op2_i = b; start_i = 1;
    #1;
    st = stall_o ? 1 : 0;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      start_i = 0; op1_i = $urandom; op2_i = $urandom; op_i = 3'($urandom);
      #1;
      n++;
      if (valid_o) begin
        seen = 1;
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_res"}, res_o, exp);
        chk({tag, "_done_stall"}, {31'b0, stall_o}, 32'd0);
      end else if (stall_o) st++;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_stall_cycles"}, 32'(st), 32'(lat));
    @(posedge clk);
    #2;
    chk({tag, "_pulse"}, {31'b0, valid_o}, 32'd0);
  endtask
  initial begin
    int vc;
    #2;
    chk("rst_res", res_o, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    reset_n = 1;
    run_op("div_7_m2", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33);
    run_op("divu_z", 3'b101, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_z", 3'b111, 32'h12345678, 32'd0, 32'h12345678, 1);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("mul_ff", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu_ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mulh_ff", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("div_m100_7", 3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
    run_op("rem_m100_7", 3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
    run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    @(negedge clk);
    op_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; start_i = 1;
    @(posedge clk);
    #1;
    start_i = 0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1;
    @(posedge clk);
    #1;
    flush_i = 0;
    #1;
    chk("flush_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_stall", {31'b0, stall_o}, 32'd0);
    chk("flush_valid", {31'b0, valid_o}, 32'd0);
    chk("flush_res", res_o, 32'h40000000);
    vc = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o) vc++;
    end
    chk("flush_no_valid", 32'(vc), 32'd0);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    @(negedge clk);
    op_i = 3'b000; op1_i = 32'd3; op2_i = 32'd5; start_i = 1;
    @(posedge clk);
    #1;
    start_i = 0;
    repeat (14) @(posedge clk);
    #1;
    reset_n = 0;
    #1;
    chk("arst_busy", {31'b0, busy_o}, 32'd0);
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    chk("arst_res", res_o, 32'd0);
    @(negedge clk);
    reset_n = 1;
    vc = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o || busy_o) vc++;
    end
    chk("arst_quiet", 32'(vc), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
